vred_seq_ctrl: RTL and testbench

//  Sequencer for the min/max/sum reduction pipeline. Accepts one reduction command, reads the

---
 rtl/vred_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vred_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vred_seq_ctrl.sv
// Reduction-pipeline sequencer: reads the seed and vs2 beats from the VRF, streams them to the
// reduction unit and reports completion. The DRAIN watchdog is built when VRED_SEQ_TIMEOUT_EN is defined.
module vred_seq_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int VRF_ADDR_WIDTH = 8,
    parameter int BEAT_WIDTH     = 8,
    parameter int OPSEL_WIDTH    = 2,
    parameter int SEW_WIDTH      = 2,
    parameter int DRAIN_MAX      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [VRF_ADDR_WIDTH-1:0] cmd_vs1_addr,
    input  logic [VRF_ADDR_WIDTH-1:0] cmd_vs2_addr,
    input  logic [ADDR_WIDTH-1:0]     cmd_vd_addr,
    input  logic [BEAT_WIDTH-1:0]     cmd_beats,
    input  logic [OPSEL_WIDTH-1:0]    cmd_opsel,
    input  logic [SEW_WIDTH-1:0]      cmd_sew,
    output logic                      rd_en,
    output logic [VRF_ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      red_valid,
    output logic                      red_start,
    output logic                      red_end,
    output logic [DATA_WIDTH-1:0]     red_vec0,
    output logic [DATA_WIDTH-1:0]     red_vec1,
    output logic [OPSEL_WIDTH-1:0]    red_opsel,
    output logic [SEW_WIDTH-1:0]      red_sew,
    output logic [ADDR_WIDTH-1:0]     red_addr,
    input  logic                      red_out_valid,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEED,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [VRF_ADDR_WIDTH-1:0] vs1_q;
    logic [VRF_ADDR_WIDTH-1:0] vs2_q;
    logic [ADDR_WIDTH-1:0]     vd_q;
    logic [BEAT_WIDTH-1:0]     beats_q;
    logic [OPSEL_WIDTH-1:0]    opsel_q;
    logic [SEW_WIDTH-1:0]      sew_q;

    logic [BEAT_WIDTH-1:0]     beat_cnt;
    logic                      seed_cap_q;
    logic [DATA_WIDTH-1:0]     seed_q;
    logic                      beat_valid_q;
    logic                      beat_start_q;
    logic                      beat_end_q;
    logic                      done_q;

    logic accept;
    logic last_beat;
    logic drain_expired;

    assign accept    = cmd_valid && cmd_ready;
    assign last_beat = (beat_cnt == beats_q - BEAT_WIDTH'(1));

`ifdef VRED_SEQ_TIMEOUT_EN
    localparam int DRAIN_CNT_W = $clog2(DRAIN_MAX + 1);

    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic                   err_q;

    assign drain_expired = (state == S_DRAIN) && (drain_cnt == DRAIN_CNT_W'(DRAIN_MAX - 1));

    // Counts completed DRAIN cycles; restarts at zero on every entry to DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + DRAIN_CNT_W'(1) : '0;
            err_q     <= drain_expired && !red_out_valid;
        end
    end

    assign err = err_q;
`else
    assign drain_expired = 1'b0;
    assign err           = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            S_IDLE:   if (accept && (cmd_beats != '0)) state_next = S_SEED;
            S_SEED:   state_next = S_STREAM;
            S_STREAM: if (last_beat) state_next = S_DRAIN;
            S_DRAIN:  if (red_out_valid || drain_expired) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output logic: VRF read port and command handshake.
    always_comb begin
        cmd_ready = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        unique case (state)
            S_IDLE:   cmd_ready = 1'b1;
            S_SEED: begin
                rd_en   = 1'b1;
                rd_addr = vs1_q;
            end
            S_STREAM: begin
                rd_en   = 1'b1;
                rd_addr = vs2_q + VRF_ADDR_WIDTH'(beat_cnt);
            end
            default: ;
        endcase
    end

    // Command fields, captured once per accepted command.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs1_q   <= '0;
            vs2_q   <= '0;
            vd_q    <= '0;
            beats_q <= '0;
            opsel_q <= '0;
            sew_q   <= '0;
        end else if (accept) begin
            vs1_q   <= cmd_vs1_addr;
            vs2_q   <= cmd_vs2_addr;
            vd_q    <= cmd_vd_addr;
            beats_q <= cmd_beats;
            opsel_q <= cmd_opsel;
            sew_q   <= cmd_sew;
        end
    end

    // Beat pipeline: a read issued this cycle has its data on rd_data next cycle, so the
    // beat flags are registered alongside it and the data itself is passed straight through.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt     <= '0;
            seed_cap_q   <= 1'b0;
            seed_q       <= '0;
            beat_valid_q <= 1'b0;
            beat_start_q <= 1'b0;
            beat_end_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            beat_cnt     <= (state == S_STREAM) ? beat_cnt + BEAT_WIDTH'(1) : '0;
            seed_cap_q   <= (state == S_SEED);
            beat_valid_q <= (state == S_STREAM);
            beat_start_q <= (state == S_STREAM) && (beat_cnt == '0);
            beat_end_q   <= (state == S_STREAM) && last_beat;
            if (seed_cap_q) seed_q <= rd_data;
            done_q <= (accept && (cmd_beats == '0)) ||
                      ((state == S_DRAIN) && (red_out_valid || drain_expired));
        end
    end

    // Beat-qualified fields read as zero between beats.
    assign red_valid = beat_valid_q;
    assign red_start = beat_start_q;
    assign red_end   = beat_end_q;
    assign red_vec0  = beat_valid_q ? rd_data : '0;
    assign red_vec1  = seed_q;
    assign red_opsel = beat_valid_q ? opsel_q : '0;
    assign red_sew   = beat_valid_q ? sew_q   : '0;
    assign red_addr  = beat_valid_q ? vd_q    : '0;
    assign done      = done_q;

endmodule

// File: tb/tb_vred_seq_ctrl.sv
// Directed bench for vred_seq_ctrl with a VRF model and a 6-cycle reduction-unit model.
// Inputs are driven and outputs sampled on the falling edge; cycle 1 is the cycle after accept.
module tb_vred_seq_ctrl;

    localparam int DW = 64, AW = 32, VAW = 8, BW = 8, OW = 2, SW = 2, DMAX = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [VAW-1:0] cmd_vs1_addr, cmd_vs2_addr;
    logic [AW-1:0]  cmd_vd_addr;
    logic [BW-1:0]  cmd_beats;
    logic [OW-1:0]  cmd_opsel;
    logic [SW-1:0]  cmd_sew;
    logic           rd_en;
    logic [VAW-1:0] rd_addr;
    logic [DW-1:0]  rd_data;
    logic           red_valid, red_start, red_end;
    logic [DW-1:0]  red_vec0, red_vec1;
    logic [OW-1:0]  red_opsel;
    logic [SW-1:0]  red_sew;
    logic [AW-1:0]  red_addr;
    logic           red_out_valid;
    logic           done, err;

    vred_seq_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VRF_ADDR_WIDTH(VAW), .BEAT_WIDTH(BW),
        .OPSEL_WIDTH(OW), .SEW_WIDTH(SW), .DRAIN_MAX(DMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_vs1_addr(cmd_vs1_addr), .cmd_vs2_addr(cmd_vs2_addr), .cmd_vd_addr(cmd_vd_addr),
        .cmd_beats(cmd_beats), .cmd_opsel(cmd_opsel), .cmd_sew(cmd_sew),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .red_valid(red_valid), .red_start(red_start), .red_end(red_end),
        .red_vec0(red_vec0), .red_vec1(red_vec1),
        .red_opsel(red_opsel), .red_sew(red_sew), .red_addr(red_addr),
        .red_out_valid(red_out_valid), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] vrf(input logic [VAW-1:0] a);
        return {8'hC0, a, 8'h5A, 32'h0123_4567, ~a};
    endfunction

    // VRF: data for a read strobe appears on the following cycle.
    always @(posedge clk) rd_data <= rd_en ? vrf(rd_addr) : '0;

    // Reduction unit: result valid 6 cycles after the end beat.
    int unit_cnt;
    bit unit_mute = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            unit_cnt      <= 0;
            red_out_valid <= 1'b0;
        end else begin
            if (red_valid && red_end) unit_cnt <= 5;
            else if (unit_cnt != 0)   unit_cnt <= unit_cnt - 1;
            red_out_valid <= (unit_cnt == 1) && !unit_mute;
        end
    end

    typedef struct {
        logic [DW-1:0] vec0;
        logic [DW-1:0] vec1;
        logic          start;
        logic          fin;
        logic [OW-1:0] opsel;
        logic [SW-1:0] sew;
        logic [AW-1:0] addr;
        int            cyc;
    } beat_t;

    beat_t          beat_log[$];
    logic [VAW-1:0] rda_log[$];
    int             rdc_log[$];
    int             done_c;
    logic           done_err, done_ready;
    int             gate_bad, ready_bad;
    int             total = 0;
    int             bad   = 0;

    bit             hold = 1'b0;
    logic [VAW-1:0] nxt_vs1, nxt_vs2;
    logic [BW-1:0]  nxt_beats;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one command to its done pulse (or the cycle limit), logging reads and beats.
    task automatic observe(input int limit);
        beat_t b;
        done_c = -1; done_err = 1'bx; done_ready = 1'bx;
        gate_bad = 0; ready_bad = 0;
        beat_log.delete(); rda_log.delete(); rdc_log.delete();
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (rd_en) begin
                rda_log.push_back(rd_addr);
                rdc_log.push_back(c);
            end
            if (red_valid) begin
                b.vec0 = red_vec0; b.vec1 = red_vec1; b.start = red_start; b.fin = red_end;
                b.opsel = red_opsel; b.sew = red_sew; b.addr = red_addr; b.cyc = c;
                beat_log.push_back(b);
            end else if (red_vec0 != '0 || red_opsel != '0 || red_sew != '0 || red_addr != '0 ||
                         red_start || red_end) begin
                gate_bad++;
            end
            if (c == 1) begin
                if (hold) begin
                    cmd_vs1_addr = nxt_vs1; cmd_vs2_addr = nxt_vs2; cmd_beats = nxt_beats;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (done) begin
                done_c = c; done_err = err; done_ready = cmd_ready;
                break;
            end
            if (cmd_ready) ready_bad++;
        end
    endtask

    task automatic send(input logic [VAW-1:0] vs1, input logic [VAW-1:0] vs2,
                        input logic [BW-1:0] n, input logic [OW-1:0] op, input logic [SW-1:0] sew,
                        input logic [AW-1:0] vd);
        cmd_vs1_addr = vs1; cmd_vs2_addr = vs2; cmd_beats = n;
        cmd_opsel = op; cmd_sew = sew; cmd_vd_addr = vd; cmd_valid = 1'b1;
        observe(60);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, reads;
        rst = 1'b1; cmd_valid = 1'b0;
        cmd_vs1_addr = '0; cmd_vs2_addr = '0; cmd_vd_addr = '0;
        cmd_beats = '0; cmd_opsel = '0; cmd_sew = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_red_valid", red_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_vec1", red_vec1, 0);
        rst = 1'b0;
        @(negedge clk);

        // N=4 command
        send(8'h10, 8'h20, 8'd4, 2'd1, 2'd3, 32'h1234_5678);
        chk("n4_done_cycle", done_c, 13);
        chk("n4_err", done_err, 0);
        chk("n4_ready_at_done", done_ready, 1);
        chk("n4_busy_ready", ready_bad, 0);
        chk("n4_gating", gate_bad, 0);
        chk("n4_reads", rda_log.size(), 5);
        chk("n4_rd0_addr", rda_log[0], 8'h10);
        chk("n4_rd0_cyc", rdc_log[0], 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("n4_rd%0d_addr", k + 1), rda_log[k+1], 8'h20 + 8'(k));
            chk($sformatf("n4_rd%0d_cyc", k + 1), rdc_log[k+1], k + 2);
        end
        chk("n4_beats", beat_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("n4_b%0d_cyc", k), beat_log[k].cyc, k + 3);
            chk($sformatf("n4_b%0d_vec0", k), beat_log[k].vec0, vrf(8'h20 + 8'(k)));
            chk($sformatf("n4_b%0d_vec1", k), beat_log[k].vec1, vrf(8'h10));
            chk($sformatf("n4_b%0d_start", k), beat_log[k].start, k == 0);
            chk($sformatf("n4_b%0d_end", k), beat_log[k].fin, k == 3);
            chk($sformatf("n4_b%0d_opsel", k), beat_log[k].opsel, 1);
            chk($sformatf("n4_b%0d_sew", k), beat_log[k].sew, 3);
            chk($sformatf("n4_b%0d_addr", k), beat_log[k].addr, 32'h1234_5678);
        end

        // N=1 command
        send(8'h40, 8'h50, 8'd1, 2'd2, 2'd1, 32'hAAAA_0004);
        chk("n1_done_cycle", done_c, 10);
        chk("n1_beats", beat_log.size(), 1);
        chk("n1_start", beat_log[0].start, 1);
        chk("n1_end", beat_log[0].fin, 1);
        chk("n1_vec0", beat_log[0].vec0, vrf(8'h50));
        chk("n1_vec1", beat_log[0].vec1, vrf(8'h40));
        chk("n1_opsel", beat_log[0].opsel, 2);

        // N=0 command
        send(8'h11, 8'h22, 8'd0, 2'd3, 2'd2, 32'h0);
        chk("n0_done_cycle", done_c, 1);
        chk("n0_reads", rda_log.size(), 0);
        chk("n0_beats", beat_log.size(), 0);
        chk("n0_ready", done_ready, 1);
        chk("n0_err", done_err, 0);

        // Address wrap, with the next command held while busy
        hold = 1'b1; nxt_vs1 = 8'h33; nxt_vs2 = 8'h60; nxt_beats = 8'd2;
        send(8'h05, 8'hFE, 8'd3, 2'd0, 2'd0, 32'hBEEF_0000);
        hold = 1'b0;
        chk("wrap_done_cycle", done_c, 12);
        chk("wrap_busy_ready", ready_bad, 0);
        chk("wrap_ready_at_done", done_ready, 1);
        chk("wrap_reads", rda_log.size(), 4);
        chk("wrap_rd1", rda_log[1], 8'hFE);
        chk("wrap_rd2", rda_log[2], 8'hFF);
        chk("wrap_rd3", rda_log[3], 8'h00);
        chk("wrap_b2_vec0", beat_log[2].vec0, vrf(8'h00));
        observe(60);
        chk("held_rd0_addr", rda_log[0], 8'h33);
        chk("held_rd0_cyc", rdc_log[0], 1);
        chk("held_done_cycle", done_c, 11);
        chk("held_b1_vec0", beat_log[1].vec0, vrf(8'h61));
        chk("held_b1_end", beat_log[1].fin, 1);

        // Reset in the middle of STREAM
        cmd_vs1_addr = 8'h70; cmd_vs2_addr = 8'h80; cmd_beats = 8'd4;
        cmd_opsel = 2'd1; cmd_sew = 2'd1; cmd_vd_addr = 32'h5555_0000; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_in_stream", red_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_cmd_ready", cmd_ready, 1);
        chk("mid_rd_en", rd_en, 0);
        chk("mid_red_valid", red_valid, 0);
        chk("mid_red_end", red_end, 0);
        chk("mid_done", done, 0);
        chk("mid_vec0", red_vec0, 0);
        chk("mid_vec1", red_vec1, 0);
        chk("mid_red_addr", red_addr, 0);
        rst = 1'b0;
        pulses = 0; reads = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
            if (rd_en || red_valid) reads++;
        end
        chk("mid_no_done", pulses, 0);
        chk("mid_no_activity", reads, 0);

`ifdef VRED_SEQ_TIMEOUT_EN
        // Result withheld: watchdog ends DRAIN after DRAIN_MAX cycles
        unit_mute = 1'b1;
        send(8'h01, 8'h02, 8'd1, 2'd0, 2'd0, 32'h0);
        unit_mute = 1'b0;
        chk("to_done_cycle", done_c, 1 + 2 + DMAX);
        chk("to_err", done_err, 1);
        chk("to_ready", done_ready, 1);
        @(negedge clk);
        chk("to_err_pulse", err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
